// File: rtl/alu_op_issue.sv
// ID->EX issue stage: decode, operand select, one-entry ID/EX register, overflow trap.
// Optional ALU_ILLEGAL_TRAP_EN: unsupported instructions trap with EXC_ILL on fire.
module alu_op_issue #(
`ifdef ALU_ILLEGAL_TRAP_EN
   parameter logic [3:0] EXC_ILL = 4'd10,
`endif
   parameter logic [2:0] RST_MOD = 3'b101,
   parameter logic [3:0] EXC_OVF = 4'd12
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] instr,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        flush,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [2:0]  alu_mod,
   output logic [4:0]  dst,
   input  logic        alu_overflow,
   output logic        exc_req,
   output logic [3:0]  exc_code,
   input  logic        exc_ack
);

   typedef enum logic [1:0] {EMPTY, FULL, TRAP} state_t;

   localparam logic [2:0] M_AND  = 3'b000;
   localparam logic [2:0] M_OR   = 3'b001;
   localparam logic [2:0] M_LT   = 3'b010;
   localparam logic [2:0] M_NOR  = 3'b011;
   localparam logic [2:0] M_ADD  = 3'b100;
   localparam logic [2:0] M_ADDU = 3'b101;
   localparam logic [2:0] M_SUB  = 3'b110;
   localparam logic [31:0] SBIT  = 32'h8000_0000;

   state_t      state;
   logic        ovf_chk;
   logic [5:0]  op;
   logic [5:0]  fn;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [31:0] sx;
   logic [31:0] zx;
   logic [31:0] d_a;
   logic [31:0] d_b;
   logic [2:0]  d_mod;
   logic [4:0]  d_dst;
   logic        d_ovf;
   logic        d_nop;
   logic        fire;
   logic        cap;
   logic        cause;
   logic        trap_hit;
   logic        ld;
   logic        clr;
   logic [3:0]  trap_code;
   logic        unused_shamt;

   assign op = instr[31:26];
   assign fn = instr[5:0];
   assign rt = instr[20:16];
   assign rd = instr[15:11];
   assign sx = {{16{instr[15]}}, instr[15:0]};
   assign zx = {16'h0000, instr[15:0]};
   assign unused_shamt = ^instr[10:6];

   always_comb begin
      d_a   = rs_val;
      d_b   = rt_val;
      d_mod = M_ADDU;
      d_dst = rd;
      d_ovf = 1'b0;
      d_nop = 1'b0;
      unique case (op)
         6'h00: begin
            unique case (fn)
               6'h20: begin
                  d_mod = M_ADD;
                  d_ovf = 1'b1;
               end
               6'h21: d_mod = M_ADDU;
               6'h22: begin
                  d_mod = M_SUB;
                  d_ovf = 1'b1;
               end
               6'h23: d_mod = M_SUB;
               6'h24: d_mod = M_AND;
               6'h25: d_mod = M_OR;
               6'h27: d_mod = M_NOR;
               // sign-bit flip turns the unsigned LT into a signed compare
               6'h2a: begin
                  d_mod = M_LT;
                  d_a   = rs_val ^ SBIT;
                  d_b   = rt_val ^ SBIT;
               end
               6'h2b: d_mod = M_LT;
               default: d_nop = 1'b1;
            endcase
         end
         6'h08: begin
            d_b   = sx;
            d_dst = rt;
            d_mod = M_ADD;
            d_ovf = 1'b1;
         end
         6'h09, 6'h23, 6'h2b: begin
            d_b   = sx;
            d_dst = rt;
            d_mod = M_ADDU;
         end
         6'h0a: begin
            d_a   = rs_val ^ SBIT;
            d_b   = sx ^ SBIT;
            d_dst = rt;
            d_mod = M_LT;
         end
         6'h0b: begin
            d_b   = sx;
            d_dst = rt;
            d_mod = M_LT;
         end
         6'h0c: begin
            d_b   = zx;
            d_dst = rt;
            d_mod = M_AND;
         end
         6'h0d: begin
            d_b   = zx;
            d_dst = rt;
            d_mod = M_OR;
         end
         default: d_nop = 1'b1;
      endcase
      if (d_nop) begin
         d_a   = '0;
         d_b   = '0;
         d_mod = M_ADDU;
         d_dst = '0;
         d_ovf = 1'b0;
      end
   end

`ifdef ALU_ILLEGAL_TRAP_EN
   logic ill;
   assign cause     = (ovf_chk && alu_overflow) || ill;
   assign trap_code = ill ? EXC_ILL : EXC_OVF;
`else
   assign cause     = ovf_chk && alu_overflow;
   assign trap_code = EXC_OVF;
`endif

   assign in_ready = (state != TRAP) && !flush
                   && (state == EMPTY || out_ready);
   assign fire     = out_valid && out_ready;
   assign cap      = in_valid && in_ready;
   assign trap_hit = fire && !flush && cause;
   // a trapping fire cancels the same-cycle capture
   assign ld       = cap && !trap_hit;
   assign clr      = (state == FULL)
                   && (flush || trap_hit || (fire && !cap));

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= EMPTY;
         out_valid <= 1'b0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_mod   <= RST_MOD;
         dst       <= '0;
         ovf_chk   <= 1'b0;
         exc_req   <= 1'b0;
         exc_code  <= '0;
      end else begin
         exc_req <= 1'b0;
         unique case (state)
            EMPTY: if (ld) state <= FULL;
            FULL: begin
               if (trap_hit) begin
                  state    <= TRAP;
                  exc_req  <= 1'b1;
                  exc_code <= trap_code;
               end else if (clr) begin
                  state <= EMPTY;
               end
            end
            TRAP: begin
               if (exc_ack) begin
                  state    <= EMPTY;
                  exc_code <= '0;
               end
            end
            default: state <= EMPTY;
         endcase
         if (ld) begin
            out_valid <= 1'b1;
            alu_a     <= d_a;
            alu_b     <= d_b;
            alu_mod   <= d_mod;
            dst       <= d_dst;
            ovf_chk   <= d_ovf;
         end else if (clr) begin
            out_valid <= 1'b0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_mod   <= RST_MOD;
            dst       <= '0;
            ovf_chk   <= 1'b0;
         end
      end
   end

`ifdef ALU_ILLEGAL_TRAP_EN
   always_ff @(posedge clk) begin
      if (rst)      ill <= 1'b0;
      else if (ld)  ill <= d_nop;
      else if (clr) ill <= 1'b0;
   end
`endif

endmodule

// File: tb/tb_alu_op_issue.sv
// Scoreboard bench for alu_op_issue with a behavioural ALU closing the overflow loop.
module tb_alu_op_issue;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [2:0]  alu_mod;
   logic [4:0]  dst;
   logic        alu_overflow;
   logic        exc_req;
   logic [3:0]  exc_code;
   logic        exc_ack;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  m;
      logic [4:0]  d;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_fail = 0;
   int   n_pop = 0;

   logic [31:0] sum;
   logic [31:0] diff;
   logic [31:0] alu_res;

   alu_op_issue dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .instr(instr), .rs_val(rs_val), .rt_val(rt_val),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .alu_a(alu_a), .alu_b(alu_b),
      .alu_mod(alu_mod), .dst(dst),
      .alu_overflow(alu_overflow),
      .exc_req(exc_req), .exc_code(exc_code),
      .exc_ack(exc_ack)
   );

   always #5 clk = ~clk;

   always_comb begin
      sum          = alu_a + alu_b;
      diff         = alu_a - alu_b;
      alu_overflow = 1'b0;
      alu_res      = 32'h0;
      case (alu_mod)
         3'b000: alu_res = alu_a & alu_b;
         3'b001: alu_res = alu_a | alu_b;
         3'b010: alu_res = {31'h0, alu_a < alu_b};
         3'b011: alu_res = ~(alu_a | alu_b);
         3'b100: begin
            alu_res = sum;
            alu_overflow = (alu_a[31] == alu_b[31])
                        && (sum[31] != alu_a[31]);
         end
         3'b101: alu_res = sum;
         3'b110: begin
            alu_res = diff;
            alu_overflow = (alu_a[31] != alu_b[31])
                        && (diff[31] != alu_a[31]);
         end
         default: alu_res = 32'h0;
      endcase
   end

   always @(negedge clk) begin : mon
      exp_t e;
      if (!rst && out_valid && out_ready) begin
         n_chk++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_extra: a=%h b=%h mod=%b dst=%0d, none expected",
                     alu_a, alu_b, alu_mod, dst);
         end else begin
            e = sb.pop_front();
            n_pop++;
            if ({alu_a, alu_b, alu_mod, dst} !== e) begin
               n_fail++;
               $display("FAIL sb_op: got a=%h b=%h mod=%b dst=%0d want a=%h b=%h mod=%b dst=%0d",
                        alu_a, alu_b, alu_mod, dst, e.a, e.b, e.m, e.d);
            end
         end
      end
   end

   function automatic logic [31:0] rtype(input logic [4:0] s, t, d,
                                         input logic [5:0] f);
      return {6'h00, s, t, d, 5'd0, f};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] o,
                                         input logic [4:0] s, t,
                                         input logic [15:0] im);
      return {o, s, t, im};
   endfunction

   function automatic exp_t mk(input logic [31:0] a, b,
                               input logic [2:0] m,
                               input logic [4:0] d);
      exp_t e;
      e.a = a; e.b = b; e.m = m; e.d = d;
      return e;
   endfunction

   task automatic send(input logic [31:0] i, r, t,
                       input exp_t e, input bit fires);
      bit done;
      done = 1'b0;
      instr = i; rs_val = r; rt_val = t; in_valid = 1'b1;
      for (int k = 0; k < 50 && !done; k++) begin
         @(negedge clk);
         if (in_ready) begin
            done = 1'b1;
            if (fires) sb.push_back(e);
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      n_chk++;
      if (!done) begin
         n_fail++;
         $display("FAIL send_timeout: instr=%h not accepted, want accept", i);
      end
   endtask

   task automatic drain();
      for (int k = 0; k < 30 && sb.size() != 0; k++) begin
         @(posedge clk); #1;
      end
      n_chk++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d ops pending, want 0", sb.size());
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      exc_ack = 1'b0; instr = '0; rs_val = '0; rt_val = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: %b want 0", out_valid); end
      n_chk++; if (alu_mod !== 3'b101) begin n_fail++; $display("FAIL rst_mod: %b want 101", alu_mod); end
      n_chk++; if (exc_req !== 1'b0) begin n_fail++; $display("FAIL rst_exc: %b want 0", exc_req); end
      n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: %b want 1", in_ready); end
      n_chk++; if ({alu_a, alu_b, dst, exc_code} !== '0) begin n_fail++; $display("FAIL rst_regs: a=%h b=%h dst=%0d code=%0d want 0", alu_a, alu_b, dst, exc_code); end
      @(posedge clk); #1;
   endtask

   task automatic test_add_ovf();
      out_ready = 1'b1;
      send(rtype(5'd1, 5'd2, 5'd3, 6'h20), 32'h7FFF_FFFF, 32'h1,
           mk(32'h7FFF_FFFF, 32'h1, 3'b100, 5'd3), 1'b1);
      instr = rtype(5'd1, 5'd2, 5'd4, 6'h21);
      rs_val = 32'd9; rt_val = 32'd9; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_chk++; if (exc_req !== 1'b1) begin n_fail++; $display("FAIL ovf_req: %b want 1", exc_req); end
      n_chk++; if (exc_code !== 4'd12) begin n_fail++; $display("FAIL ovf_code: %0d want 12", exc_code); end
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_valid: %b want 0", out_valid); end
      n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_ready: %b want 0", in_ready); end
      @(posedge clk); #1;
      n_chk++; if (exc_req !== 1'b0) begin n_fail++; $display("FAIL ovf_pulse: %b want 0", exc_req); end
      n_chk++; if (exc_code !== 4'd12) begin n_fail++; $display("FAIL ovf_hold: %0d want 12", exc_code); end
      n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL trap_ready: %b want 0", in_ready); end
      exc_ack = 1'b1;
      @(posedge clk); #1;
      exc_ack = 1'b0;
      n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ack_ready: %b want 1", in_ready); end
      n_chk++; if (exc_code !== 4'd0) begin n_fail++; $display("FAIL ack_code: %0d want 0", exc_code); end
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drop_valid: %b want 0", out_valid); end
   endtask

   task automatic test_subu();
      bit seen;
      out_ready = 1'b1;
      send(rtype(5'd1, 5'd2, 5'd5, 6'h23), 32'h8000_0000, 32'h1,
           mk(32'h8000_0000, 32'h1, 3'b110, 5'd5), 1'b1);
      send(rtype(5'd6, 5'd7, 5'd8, 6'h21), 32'd5, 32'd6,
           mk(32'd5, 32'd6, 3'b101, 5'd8), 1'b1);
      seen = 1'b0;
      for (int k = 0; k < 3; k++) begin
         seen |= exc_req;
         @(posedge clk); #1;
      end
      n_chk++; if (seen !== 1'b0) begin n_fail++; $display("FAIL subu_exc: %b want 0", seen); end
      n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL subu_ready: %b want 1", in_ready); end
      drain();
   endtask

   task automatic test_decode();
      out_ready = 1'b1;
      send(itype(6'h0a, 5'd4, 5'd5, 16'h0001), 32'hFFFF_FFFF, 32'h0,
           mk(32'h7FFF_FFFF, 32'h8000_0001, 3'b010, 5'd5), 1'b1);
      n_chk++; if (alu_res !== 32'd1) begin n_fail++; $display("FAIL slti_res: %h want 1", alu_res); end
      send(itype(6'h0b, 5'd4, 5'd5, 16'h0001), 32'hFFFF_FFFF, 32'h0,
           mk(32'hFFFF_FFFF, 32'h1, 3'b010, 5'd5), 1'b1);
      n_chk++; if (alu_res !== 32'd0) begin n_fail++; $display("FAIL sltiu_res: %h want 0", alu_res); end
      send(rtype(5'd1, 5'd2, 5'd3, 6'h2a), 32'h1, 32'hFFFF_FFFF,
           mk(32'h8000_0001, 32'h7FFF_FFFF, 3'b010, 5'd3), 1'b1);
      n_chk++; if (alu_res !== 32'd0) begin n_fail++; $display("FAIL slt_res: %h want 0", alu_res); end
      send(itype(6'h0c, 5'd1, 5'd9, 16'h8001), 32'hFFFF_FFFF, 32'h0,
           mk(32'hFFFF_FFFF, 32'h0000_8001, 3'b000, 5'd9), 1'b1);
      send(itype(6'h23, 5'd2, 5'd10, 16'hFFFC), 32'h100, 32'h0,
           mk(32'h100, 32'hFFFF_FFFC, 3'b101, 5'd10), 1'b1);
      send(itype(6'h08, 5'd2, 5'd11, 16'hFFFF), 32'd5, 32'h0,
           mk(32'd5, 32'hFFFF_FFFF, 3'b100, 5'd11), 1'b1);
      send(rtype(5'd1, 5'd2, 5'd12, 6'h22), 32'd5, 32'd3,
           mk(32'd5, 32'd3, 3'b110, 5'd12), 1'b1);
      send(rtype(5'd1, 5'd2, 5'd13, 6'h27), 32'hF0, 32'h0F,
           mk(32'hF0, 32'h0F, 3'b011, 5'd13), 1'b1);
      send(rtype(5'd1, 5'd2, 5'd14, 6'h26), 32'h11, 32'h22,
           mk(32'h0, 32'h0, 3'b101, 5'd0), 1'b1);
      drain();
      n_chk++; if (exc_code !== 4'd0) begin n_fail++; $display("FAIL decode_exc: %0d want 0", exc_code); end
   endtask

   task automatic test_back_to_back();
      int   p0;
      exp_t snap;
      p0 = n_pop;
      out_ready = 1'b1;
      fork
         begin
            for (int i = 0; i < 3; i++)
               send(itype(6'h0d, 5'd1, 5'(20 + i), 16'(16'h8000 | i)),
                    32'(i * 16), 32'h0,
                    mk(32'(i * 16), 32'h8000 | 32'(i), 3'b001, 5'(20 + i)),
                    1'b1);
         end
         begin
            repeat (2) @(posedge clk);
            #1 out_ready = 1'b0;
            @(negedge clk);
            snap = {alu_a, alu_b, alu_mod, dst};
            @(posedge clk); #1;
            @(posedge clk); #1;
            n_chk++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid: %b want 1", out_valid); end
            n_chk++; if ({alu_a, alu_b, alu_mod, dst} !== snap) begin n_fail++; $display("FAIL stall_hold: a=%h want a=%h", alu_a, snap.a); end
            out_ready = 1'b1;
         end
      join
      drain();
      n_chk++; if (n_pop - p0 !== 3) begin n_fail++; $display("FAIL b2b_count: %0d want 3", n_pop - p0); end
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      send(itype(6'h0d, 5'd1, 5'd2, 16'h0055), 32'h1, 32'h0,
           mk(32'h0, 32'h0, 3'b000, 5'd0), 1'b0);
      flush = 1'b1; in_valid = 1'b1;
      instr = itype(6'h0d, 5'd1, 5'd3, 16'h0066);
      #1;
      n_chk++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: %b want 0", in_ready); end
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: %b want 0", out_valid); end
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_nocap: %b want 0", out_valid); end
      n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_after: %b want 1", in_ready); end
   endtask

   task automatic test_rst_mid();
      out_ready = 1'b0;
      send(itype(6'h0d, 5'd1, 5'd2, 16'h0077), 32'h5, 32'h0,
           mk(32'h0, 32'h0, 3'b000, 5'd0), 1'b0);
      rst = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; in_valid = 1'b0;
      n_chk++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: %b want 0", out_valid); end
      n_chk++; if ({alu_a, alu_mod} !== {32'h0, 3'b101}) begin n_fail++; $display("FAIL rstmid_regs: a=%h mod=%b want 0/101", alu_a, alu_mod); end
   endtask

   task automatic test_illegal();
      out_ready = 1'b1;
      send({6'h3f, 26'h3FF_FFFF}, 32'h1234, 32'h5678,
           mk(32'h0, 32'h0, 3'b101, 5'd0), 1'b1);
      @(posedge clk); #1;
`ifdef ALU_ILLEGAL_TRAP_EN
      n_chk++; if (exc_req !== 1'b1) begin n_fail++; $display("FAIL ill_req: %b want 1", exc_req); end
      n_chk++; if (exc_code !== 4'd10) begin n_fail++; $display("FAIL ill_code: %0d want 10", exc_code); end
      exc_ack = 1'b1;
      @(posedge clk); #1;
      exc_ack = 1'b0;
      n_chk++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ill_ack: %b want 1", in_ready); end
`else
      n_chk++; if (exc_req !== 1'b0) begin n_fail++; $display("FAIL nop_req: %b want 0", exc_req); end
      n_chk++; if (exc_code !== 4'd0) begin n_fail++; $display("FAIL nop_code: %0d want 0", exc_code); end
`endif
      drain();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_add_ovf();
      test_subu();
      test_decode();
      test_back_to_back();
      test_flush();
      test_rst_mid();
      test_illegal();
      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
